// File: rtl/spi_target.sv
// SPI mode 0 target: oversampled sck/ss_n/mosi on the system clock, single transmit
// buffer with bypass on frame start, and one-cycle rx_valid per completed frame.
module spi_target #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  sck,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_wr,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic                   sck_d, ss_d;
    logic [SYNC_STAGES:0]   settle;

    logic                   sck_s, ss_s, mosi_s, edges_ok;
    logic                   sck_rise, sck_fall, ss_fall, ss_rise;

    logic [DATA_WIDTH-1:0]  tx_sr, tx_buf, rx_sr, rx_next;
    logic                   tx_full;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   load, wr_accept, underrun_set;

    // Synchronizers reset to the bus idle levels; the settle chain masks the edges that
    // appear while the chains fill after reset, so a select held low is not mistaken for a fall.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            ss_d      <= 1'b1;
            settle    <= '0;
        end else begin
            sck_sync[0]  <= sck;
            ss_sync[0]   <= ss_n;
            mosi_sync[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_sync[i]  <= sck_sync[i-1];
                ss_sync[i]   <= ss_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
            sck_d  <= sck_sync[SYNC_STAGES-1];
            ss_d   <= ss_sync[SYNC_STAGES-1];
            settle <= {settle[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign edges_ok = settle[SYNC_STAGES];
    assign sck_rise = edges_ok &  sck_s & ~sck_d;
    assign sck_fall = edges_ok & ~sck_s &  sck_d;
    assign ss_fall  = edges_ok & ~ss_s  &  ss_d;
    assign ss_rise  = edges_ok &  ss_s  & ~ss_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = ACTIVE;
            ACTIVE:  if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        miso_oe = 1'b0;
        miso    = 1'b0;
        if (state == ACTIVE) begin
            busy    = 1'b1;
            miso_oe = 1'b1;
            miso    = tx_sr[DATA_WIDTH-1];
        end
    end

    // A load happens at frame start and on the falling sck edge that closes each frame.
    assign load         = ((state == IDLE) && ss_fall) ||
                          ((state == ACTIVE) && !ss_rise && sck_fall && (bit_cnt == '0));
    assign wr_accept    = tx_wr && !tx_full;
    assign underrun_set = load && !tx_full && !tx_wr;
    assign tx_ready     = ~tx_full;
    assign rx_next      = {rx_sr[DATA_WIDTH-2:0], mosi_s};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx_sr       <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            if (load) begin
                if (tx_full) begin
                    tx_sr <= tx_buf;
                end else if (tx_wr) begin
                    tx_sr <= tx_data;
                end else begin
                    tx_sr <= '1;
                end
            end else if ((state == ACTIVE) && sck_fall) begin
                tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
            end

            // A write that coincides with an empty-buffer load goes straight to the shifter.
            if (load && tx_full) begin
                tx_full <= 1'b0;
            end else if (wr_accept && !load) begin
                tx_full <= 1'b1;
                tx_buf  <= tx_data;
            end

            if (underrun_set) begin
                tx_underrun <= 1'b1;
            end else if (wr_accept) begin
                tx_underrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            bit_cnt  <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (state == ACTIVE) begin
                if (ss_rise) begin
                    bit_cnt <= '0;
                    rx_sr   <= '0;
                end else if (sck_rise) begin
                    rx_sr <= rx_next;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt  <= '0;
                        rx_data  <= rx_next;
                        rx_valid <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
            end else if (ss_fall) begin
                bit_cnt <= '0;
                rx_sr   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: a bit-banged mode 0 master plus queues of
// expected received words and expected miso words.
module tb_spi_target;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic         clk = 1'b0;
    logic         nrst;
    logic         sck, ss_n, mosi, tx_wr;
    logic [W-1:0] tx_data;
    logic         miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic [W-1:0] rx_data;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] rx_q[$];
    logic [W-1:0] miso_q[$];
    logic [W-1:0] exp_rx;

    spi_target #(.DATA_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .sck         (sck),
        .ss_n        (ss_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_wr       (tx_wr),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Every rx_valid cycle must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (nrst === 1'b1 && rx_valid === 1'b1) begin
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL rx_unexpected: rx_valid with rx_data=%h, required no rx_valid", rx_data);
            end else begin
                exp_rx = rx_q.pop_front();
                if (rx_data !== exp_rx) begin
                    errors++;
                    $display("[TB] FAIL rx_data: got %h, required %h", rx_data, exp_rx);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        nrst = 1'b0; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_wr = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic write_tx(input logic [W-1:0] d);
        @(negedge clk);
        tx_data = d;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    task automatic select();
        int n;
        @(negedge clk);
        ss_n = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_bit("select_busy", busy, 1'b1);
    endtask

    task automatic deselect();
        int n;
        @(negedge clk);
        ss_n = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_bit("deselect_busy", busy, 1'b0);
        check_bit("deselect_miso_oe", miso_oe, 1'b0);
        check_bit("deselect_miso", miso, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [W-1:0] out_word, input int nbits, output logic [W-1:0] in_word);
        in_word = '0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            mosi = out_word[W-1-i];
            repeat (HALF) @(negedge clk);
            in_word = {in_word[W-2:0], miso};
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic run_frame(input logic [W-1:0] mosi_word);
        logic [W-1:0] got;
        logic [W-1:0] req;
        rx_q.push_back(mosi_word);
        shift_bits(mosi_word, W, got);
        checks++;
        if (miso_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL miso_frame: got %h, no expected word queued", got);
        end else begin
            req = miso_q.pop_front();
            if (got !== req) begin
                errors++;
                $display("[TB] FAIL miso_frame: got %h, required %h", got, req);
            end
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s: %0d rx words never delivered, required 0", name, rx_q.size());
            rx_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (miso !== 1'b0 || miso_oe !== 1'b0 || tx_ready !== 1'b1 || rx_data !== '0 ||
            rx_valid !== 1'b0 || tx_underrun !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s: miso=%b oe=%b ready=%b rx_data=%h valid=%b underrun=%b busy=%b, required 0 0 1 00 0 0 0",
                     name, miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_wr = 1'b0; tx_data = '0;
        #1;
        check_reset_outputs("reset_asserted");
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (6) @(negedge clk);
        check_reset_outputs("reset_released");
    endtask

    task automatic test_bypass();
        @(negedge clk);
        ss_n = 1'b0;
        repeat (SYNC) @(negedge clk);
        tx_data = 8'h77;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
        check_bit("bypass_busy", busy, 1'b1);
        check_bit("bypass_tx_ready", tx_ready, 1'b1);
        check_bit("bypass_underrun", tx_underrun, 1'b0);
        miso_q.push_back(8'h77);
        run_frame(8'h96);
        deselect();
        check_drained("bypass_rx");
    endtask

    task automatic test_basic();
        write_tx(8'hA5);
        miso_q.push_back(8'hA5);
        check_bit("basic_tx_ready_full", tx_ready, 1'b0);
        select();
        check_bit("basic_tx_ready_loaded", tx_ready, 1'b1);
        check_bit("basic_first_miso", miso, 1'b1);
        run_frame(8'h3C);
        deselect();
        check_drained("basic_rx");
    endtask

    task automatic test_back_to_back();
        write_tx(8'hC3);
        miso_q.push_back(8'hC3);
        select();
        write_tx(8'h5A);
        miso_q.push_back(8'h5A);
        check_bit("b2b_tx_ready_full", tx_ready, 1'b0);
        run_frame(8'h11);
        run_frame(8'h22);
        deselect();
        check_drained("b2b_rx");
    endtask

    task automatic test_underrun();
        pulse_reset();
        check_bit("underrun_clear_start", tx_underrun, 1'b0);
        miso_q.push_back(8'hFF);
        select();
        check_bit("underrun_set", tx_underrun, 1'b1);
        run_frame(8'hFF);
        deselect();
        check_drained("underrun_rx");
        write_tx(8'h01);
        check_bit("underrun_cleared", tx_underrun, 1'b0);
        check_bit("underrun_tx_ready", tx_ready, 1'b0);
    endtask

    task automatic test_abort();
        logic [W-1:0] got;
        select();
        shift_bits(8'hB5, 5, got);
        checks++;
        if (got[4:0] !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL abort_miso_bits: got %b, required 00000", got[4:0]);
        end
        deselect();
        check_drained("abort_rx");
        miso_q.push_back(8'hFF);
        select();
        run_frame(8'h81);
        deselect();
        check_drained("abort_next_rx");
        checks++;
        if (rx_data !== 8'h81) begin
            errors++;
            $display("[TB] FAIL abort_next_rx_data: got %h, required 81", rx_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] got;
        write_tx(8'h3C);
        select();
        write_tx(8'h99);
        shift_bits(8'h5A, 3, got);
        @(negedge clk);
        sck = 1'b1;
        #2;
        nrst = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        repeat (3) @(negedge clk);
        sck  = 1'b0;
        nrst = 1'b1;
        repeat (30) @(negedge clk);
        check_bit("midframe_stay_idle", busy, 1'b0);
        deselect();
        miso_q.push_back(8'hFF);
        select();
        run_frame(8'h5C);
        deselect();
        check_drained("midframe_recover_rx");
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_basic();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid_frame();
        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
